// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-port arbiter in front of a single synchronous-read memory
module lc3_mem_arbiter #(
    parameter int PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        memWE,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_winner;   // port owning the in-flight transaction
    logic   r_we;       // in-flight transaction is a write (no read capture)
    logic   r_last;     // port served most recently, drives round-robin ties
    logic   w_req_any;
    logic   w_win;

    // Pick the port to serve if a request is accepted this cycle
    always_comb begin
        w_req_any = req0 | req1;
        w_win     = 1'b0;
        if (req0 && req1) begin
            w_win = (PRIO == 1) ? 1'b0 : ~r_last;
        end else begin
            w_win = req1;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                gnt0        = ~r_winner;
                gnt1        = r_winner;
                w_state_nxt = RESP;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-side registers: loaded on acceptance, write enable lives for ACCESS only
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            memWE     <= 1'b0;
            r_winner  <= 1'b0;
            r_we      <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            memWE <= 1'b0;
            if (r_state == IDLE && w_req_any) begin
                mem_addr  <= w_win ? addr1 : addr0;
                mem_wdata <= w_win ? wdata1 : wdata0;
                memWE     <= w_win ? we1 : we0;
                r_we      <= w_win ? we1 : we0;
                r_winner  <= w_win;
                r_last    <= w_win;
            end
        end
    end

    // Completion pulse and read-data capture at the edge ending RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= 16'h0000;
            rdata1  <= 16'h0000;
        end else begin
            rvalid0 <= (r_state == RESP) && !r_winner;
            rvalid1 <= (r_state == RESP) && r_winner;
            if (r_state == RESP && !r_we) begin
                if (r_winner) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end
        end
    end

endmodule
